// File: rtl/delay_tap_ctrl.sv
`default_nettype none
// =============================================================================
// Module : delay_tap_ctrl
// Brief  : Tap-select controller for a 32-tap input delay element. Supports
//          manual up/down stepping and a calibration sweep that centres the
//          code in the widest passing window.
// Rev    : 1.0
// =============================================================================
module delay_tap_ctrl #(
    parameter int unsigned SETTLE   = 4,
    parameter int unsigned SAMPLES  = 8,
    parameter int unsigned INIT_TAP = 0
) (
    input  logic CLK,
    input  logic RSTN,
    input  logic START,
    input  logic MOVE,
    input  logic DIRECTION,
    input  logic CMP_OK,
    output logic DEL0,
    output logic DEL1,
    output logic DEL2,
    output logic DEL3,
    output logic DEL4,
    output logic BUSY,
    output logic DONE,
    output logic FAIL
);

    localparam logic [7:0] C_SETTLE_LAST  = 8'(SETTLE - 1);
    localparam logic [7:0] C_SAMPLES_LAST = 8'(SAMPLES - 1);
    localparam logic [4:0] C_INIT_TAP     = 5'(INIT_TAP);
    localparam logic [4:0] C_TAP_MAX      = 5'd31;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_EVAL   = 3'd3,
        ST_CENTER = 3'd4
    } state_t;

    state_t     state_q,      state_d;
    logic [4:0] code_q,       code_d;
    logic [4:0] restore_q,    restore_d;
    logic [7:0] cnt_q,        cnt_d;
    logic       pass_q,       pass_d;
    logic [4:0] cur_start_q,  cur_start_d;
    logic [5:0] cur_len_q,    cur_len_d;
    logic [4:0] best_start_q, best_start_d;
    logic [5:0] best_len_q,   best_len_d;
    logic       busy_q,       busy_d;
    logic       done_q,       done_d;
    logic       fail_q,       fail_d;

    logic [4:0] win_start;
    logic [5:0] win_len;
    logic [4:0] centre;

    // Window candidate after scoring the current tap
    always_comb begin
        win_start = cur_start_q;
        win_len   = 6'd0;
        if (pass_q) begin
            win_start = (cur_len_q == 6'd0) ? code_q : cur_start_q;
            win_len   = cur_len_q + 6'd1;
        end
    end

    assign centre = best_start_q + 5'((best_len_q - 6'd1) >> 1);

    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        restore_d    = restore_q;
        cnt_d        = cnt_q;
        pass_d       = pass_q;
        cur_start_d  = cur_start_q;
        cur_len_d    = cur_len_q;
        best_start_d = best_start_q;
        best_len_d   = best_len_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        fail_d       = fail_q;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d      = ST_SETTLE;
                    restore_d    = code_q;
                    code_d       = 5'd0;
                    cnt_d        = 8'd0;
                    busy_d       = 1'b1;
                    fail_d       = 1'b0;
                    cur_start_d  = 5'd0;
                    cur_len_d    = 6'd0;
                    best_start_d = 5'd0;
                    best_len_d   = 6'd0;
                end else if (MOVE) begin
                    if (DIRECTION && (code_q != C_TAP_MAX)) begin
                        code_d = code_q + 5'd1;
                    end else if (!DIRECTION && (code_q != 5'd0)) begin
                        code_d = code_q - 5'd1;
                    end
                end
            end

            ST_SETTLE: begin
                if (cnt_q == C_SETTLE_LAST) begin
                    cnt_d   = 8'd0;
                    pass_d  = 1'b1;
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            ST_SAMPLE: begin
                pass_d = pass_q & CMP_OK;
                if (cnt_q == C_SAMPLES_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = ST_EVAL;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            ST_EVAL: begin
                cur_start_d = win_start;
                cur_len_d   = win_len;
                // Strictly greater keeps the lowest window on a tie
                if (win_len > best_len_q) begin
                    best_start_d = win_start;
                    best_len_d   = win_len;
                end
                if (code_q != C_TAP_MAX) begin
                    code_d  = code_q + 5'd1;
                    state_d = ST_SETTLE;
                end else begin
                    state_d = ST_CENTER;
                end
            end

            ST_CENTER: begin
                if (best_len_q != 6'd0) begin
                    code_d = centre;
                end else begin
                    code_d = restore_q;
                    fail_d = 1'b1;
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q      <= ST_IDLE;
            code_q       <= C_INIT_TAP;
            restore_q    <= 5'd0;
            cnt_q        <= 8'd0;
            pass_q       <= 1'b0;
            cur_start_q  <= 5'd0;
            cur_len_q    <= 6'd0;
            best_start_q <= 5'd0;
            best_len_q   <= 6'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            restore_q    <= restore_d;
            cnt_q        <= cnt_d;
            pass_q       <= pass_d;
            cur_start_q  <= cur_start_d;
            cur_len_q    <= cur_len_d;
            best_start_q <= best_start_d;
            best_len_q   <= best_len_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
        end
    end

    assign DEL0 = code_q[0];
    assign DEL1 = code_q[1];
    assign DEL2 = code_q[2];
    assign DEL3 = code_q[3];
    assign DEL4 = code_q[4];
    assign BUSY = busy_q;
    assign DONE = done_q;
    assign FAIL = fail_q;

endmodule
`default_nettype wire

// File: tb/tb_delay_tap_ctrl.sv
`default_nettype none
// =============================================================================
// Module : tb_delay_tap_ctrl
// Brief  : Randomised self-checking bench for delay_tap_ctrl against a
//          behavioural sweep model. Rev 1.0
// =============================================================================
module tb_delay_tap_ctrl;

    localparam int S        = 4;
    localparam int M        = 8;
    localparam int P        = S + M + 1;
    localparam int INIT     = 7;
    localparam int BUSY_CYC = 32 * P + 1;

    logic CLK = 1'b0;
    logic RSTN = 1'b1;
    logic START = 1'b0;
    logic MOVE = 1'b0;
    logic DIRECTION = 1'b0;
    logic CMP_OK;
    logic DEL0, DEL1, DEL2, DEL3, DEL4, BUSY, DONE, FAIL;

    logic [31:0] pass_map   = '0;
    logic        glitch_dir = 1'b0;
    logic        glitch_rnd = 1'b0;
    logic        rnd_en     = 1'b0;
    logic        chk_en     = 1'b0;
    logic [4:0]  del;

    int n_checks = 0;
    int n_fail   = 0;

    assign del    = {DEL4, DEL3, DEL2, DEL1, DEL0};
    assign CMP_OK = pass_map[del] & ~glitch_dir & ~glitch_rnd;

    delay_tap_ctrl #(.SETTLE(S), .SAMPLES(M), .INIT_TAP(INIT)) dut (
        .CLK(CLK), .RSTN(RSTN), .START(START), .MOVE(MOVE),
        .DIRECTION(DIRECTION), .CMP_OK(CMP_OK),
        .DEL0(DEL0), .DEL1(DEL1), .DEL2(DEL2), .DEL3(DEL3), .DEL4(DEL4),
        .BUSY(BUSY), .DONE(DONE), .FAIL(FAIL)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) glitch_rnd <= rnd_en && ($urandom_range(0, 39) == 0);

    // ---------------- behavioural model ----------------
    int          m_code = INIT;
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    bit          m_fail = 1'b0;
    int          m_n    = 0;
    int          m_saved = 0;
    logic [31:0] tap_ok = '1;

    // Longest run of passing taps, earliest start on ties; -1 if none
    function automatic int window_centre(input logic [31:0] ok);
        int bs = 0;
        int bl = 0;
        for (int s = 0; s < 32; s++) begin
            int len = 0;
            while ((s + len < 32) && ok[s + len]) len++;
            if (len > bl) begin
                bl = len;
                bs = s;
            end
        end
        return (bl == 0) ? -1 : bs + (bl - 1) / 2;
    endfunction

    always @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            m_code <= INIT;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_fail <= 1'b0;
            m_n    <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (m_n < 32 * P && (m_n % P) >= S && (m_n % P) < S + M && !CMP_OK)
                    tap_ok[m_n / P] <= 1'b0;
                m_n <= m_n + 1;
                if (m_n + 1 <= 32 * P) begin
                    m_code <= ((m_n + 1) / P > 31) ? 31 : (m_n + 1) / P;
                end else begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    if (window_centre(tap_ok) < 0) begin
                        m_code <= m_saved;
                        m_fail <= 1'b1;
                    end else begin
                        m_code <= window_centre(tap_ok);
                    end
                end
            end else if (START) begin
                m_saved <= m_code;
                m_code  <= 0;
                m_busy  <= 1'b1;
                m_fail  <= 1'b0;
                m_n     <= 0;
                tap_ok  <= '1;
            end else if (MOVE) begin
                if (DIRECTION) m_code <= (m_code == 31) ? 31 : m_code + 1;
                else           m_code <= (m_code == 0) ? 0 : m_code - 1;
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            n_checks++;
            if ({del, BUSY, DONE, FAIL} !== {5'(m_code), m_busy, m_done, m_fail}) begin
                n_fail++;
                $display("FAIL cycle_cmp t=%0t: got del=%0d busy=%b done=%b flag=%b, want del=%0d busy=%b done=%b flag=%b",
                         $time, del, BUSY, DONE, FAIL, m_code, m_busy, m_done, m_fail);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic step(input bit dir, input int n);
        DIRECTION = dir;
        MOVE = 1'b1;
        repeat (n) tick();
        MOVE = 1'b0;
    endtask

    // Runs one sweep; gcyc >= 0 forces CMP_OK low in that cycle of the sweep
    task automatic run_cal(input string nm, input logic [31:0] map, input bit noise,
                           input int gcyc, input int exp_code, input int exp_fail);
        int busy_cnt = 0;
        bit got_done = 1'b0;
        pass_map = map;
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int i = 0; i < 1000 && !got_done; i++) begin
            if (DONE) begin
                got_done = 1'b1;
            end else begin
                if (BUSY) busy_cnt++;
                glitch_dir = (i == gcyc);
                if (noise) begin
                    START     = 1'($urandom_range(0, 1));
                    MOVE      = 1'($urandom_range(0, 1));
                    DIRECTION = 1'($urandom_range(0, 1));
                end
                tick();
            end
        end
        START = 1'b0;
        MOVE = 1'b0;
        glitch_dir = 1'b0;
        check({nm, "_done_seen"}, int'(got_done), 1);
        check({nm, "_busy_cycles"}, busy_cnt, BUSY_CYC);
        if (exp_code >= 0) check({nm, "_code"}, int'(del), exp_code);
        if (exp_fail >= 0) check({nm, "_fail"}, int'(FAIL), exp_fail);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #3 RSTN = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        check("reset_code", int'(del), INIT);
        check("reset_busy", int'(BUSY), 0);
        check("reset_done", int'(DONE), 0);
        check("reset_fail", int'(FAIL), 0);
        #2 RSTN = 1'b1;
        tick();

        step(1'b0, 7);
        check("dec_to_zero", int'(del), 0);
        step(1'b0, 3);
        tick();
        check("sat_low", int'(del), 0);
        step(1'b1, 40);
        tick();
        check("sat_high", int'(del), 31);

        for (int i = 0; i < 60; i++) begin
            MOVE = 1'($urandom_range(0, 1));
            DIRECTION = 1'($urandom_range(0, 1));
            tick();
        end
        MOVE = 1'b0;

        run_cal("single", 32'h001F_FC00, 1'b0, -1, 15, 0);
        run_cal("two_win", 32'h0FF0_0078, 1'b0, -1, 23, 0);
        run_cal("tie", 32'h0000_F03C, 1'b0, -1, 3, 0);

        step(1'b1, 6);
        tick();
        check("preset_9", int'(del), 9);
        run_cal("no_pass", 32'h0000_0000, 1'b0, -1, 9, 1);

        run_cal("settle_glitch", 32'h001F_FC00, 1'b0, 15 * P + S - 1, 15, 0);
        run_cal("sample_glitch", 32'h001F_FC00, 1'b0, 15 * P + S + M - 1, 12, 0);

        rnd_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < int'($urandom_range(0, 20)); i++) begin
                MOVE = 1'b1;
                DIRECTION = 1'($urandom_range(0, 1));
                tick();
            end
            MOVE = 1'b0;
            run_cal("random", (k[0] ? $urandom : ($urandom | $urandom)), 1'b1, -1, -1, -1);
        end
        rnd_en = 1'b0;

        pass_map = 32'h001F_FC00;
        START = 1'b1;
        tick();
        START = 1'b0;
        repeat (199) tick();
        #2 RSTN = 1'b0;
        #1;
        check("abort_code", int'(del), INIT);
        check("abort_busy", int'(BUSY), 0);
        check("abort_done", int'(DONE), 0);
        tick();
        tick();
        #2 RSTN = 1'b1;
        repeat (5) tick();
        check("abort_no_done", int'(DONE), 0);
        run_cal("after_abort", 32'h001F_FC00, 1'b0, -1, 15, 0);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/delay_tap_ctrl.md
# delay_tap_ctrl

Sequential controller that drives the 5-bit tap-select inputs (DEL0..DEL4) of the programmable input delay element. It sits directly upstream of the delay element:
- In manual mode it steps the tap code up or down on request.
- In calibration mode it sweeps all 32 taps, scores each tap from an external data-compare flag, and parks the code at the centre of the widest passing window.

## Interface

Parameters
- SETTLE, default 4: cycles waited after each tap change before sampling begins (range 1..255).
- SAMPLES, default 8: consecutive CMP_OK cycles a tap must pass (range 1..255).
- INIT_TAP, default 0: tap code loaded at reset (0..31).

Ports
- CLK, input, 1: single clock; all state updates on the rising edge.
- RSTN, input, 1: asynchronous, active-low reset.
- START, input, 1: begins calibration when sampled high in IDLE.
- MOVE, input, 1: manual step request, honoured in IDLE only, one step per high cycle.
- DIRECTION, input, 1: step direction with MOVE; 1 = increment, 0 = decrement.
- CMP_OK, input, 1: 1 when the data captured through the delay element matched the expected pattern this cycle.
- DEL0..DEL4, output, 1 each: tap code to the delay element; DEL0 is the LSB.
- BUSY, output, 1: high while a calibration is in progress.
- DONE, output, 1: one-cycle pulse when calibration ends, on pass or fail.
- FAIL, output, 1: high after a calibration that found no passing tap; cleared by the next START.

## Operation

- Reset values: tap code = INIT_TAP, BUSY=0, DONE=0, FAIL=0, FSM=IDLE, all counters and window registers = 0.
- IDLE:
  - MOVE=1 steps the tap code ±1 per cycle.
  - The code saturates at 0 and 31; it never wraps.
  - START has priority over MOVE in the same cycle.
- Calibration FSM states: IDLE, SETTLE, SAMPLE, EVAL, CENTER.
  - IDLE → SETTLE on START. On that edge:
    - save the current code as the restore value;
    - set code=0, BUSY=1, FAIL=0;
    - clear the window registers.
  - SETTLE: count SETTLE cycles, ignoring CMP_OK, then go to SAMPLE.
  - SAMPLE: count SAMPLES cycles. The tap passes only if CMP_OK=1 on every one of those cycles. Go to EVAL.
  - EVAL, one cycle: update the window, then:
    - if code<31: code+1 and go to SETTLE;
    - else go to CENTER.
  - CENTER, one cycle: write the final code, pulse DONE, drop BUSY, go to IDLE.
- Window tracking uses cur_start/cur_len and best_start/best_len. Lengths are 6 bits (max 32).
  - Passing tap: if cur_len=0, set cur_start=code. Then cur_len+1.
  - Failing tap: set cur_len=0.
  - After each update, if cur_len > best_len (strictly greater), copy cur into best. On equal-length windows the lowest-tap window wins.
- Final code:
  - best_len>0: code = best_start + ((best_len−1)>>1), floor centre, 5-bit result.
  - best_len=0: restore the saved code and set FAIL=1.
- During BUSY, MOVE and START are ignored.
- RSTN low at any point, including mid-sweep, immediately forces all reset values. No DONE pulse is produced for the aborted calibration.

## Timing

- Manual step: the new code is visible on DEL* the cycle after MOVE is sampled.
- START sampled at edge k: code=0 and BUSY=1 from edge k.
- Each tap costs SETTLE+SAMPLES+1 cycles.
- BUSY stays high for 32·(SETTLE+SAMPLES+1)+1 cycles; with the defaults that is 417.
- DONE is high during the CENTER→IDLE cycle, coincident with the final code first appearing on DEL* and BUSY falling.
- A START in the cycle immediately after DONE is accepted.
- DEL* change only on clock edges and are glitch-free registered outputs.

## Test plan

- Reset: assert RSTN=0 with INIT_TAP=7 → DEL*=7, BUSY=0, DONE=0, FAIL=0.
- Manual saturation: from 0, DIRECTION=0 with MOVE for 3 cycles → stays 0. DIRECTION=1 with MOVE for 40 cycles → 31 and holds.
- Single window: CMP_OK high only while taps 10..20 are selected → DONE after 417 cycles, DEL*=15, FAIL=0.
- Two windows and a tie:
  - passes on 3..6 and 20..27 → DEL*=23;
  - passes on 2..5 and 12..15 → DEL*=3 (lowest window wins).
- No pass: start from code 9, CMP_OK always 0 → DONE pulse, FAIL=1, DEL*=9.
  - A single CMP_OK=0 cycle inside SAMPLE fails that tap.
  - A CMP_OK=0 during SETTLE does not fail the tap.
- Abort: RSTN low at cycle 200 of a sweep → immediate reset values, no DONE. A new START then completes normally.
